// File: rtl/cpc_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpc_bus_pkg
// Shared definitions for the CPC expansion-bus RAM expander.
//   mode_e      : Gate Array RAM-configuration modes (CFG[2:0])
//   GA_RAM_SEL  : D[7:6] function code selecting the RAM-configuration register
//   cap_state_e : I/O-write capture FSM states
// -----------------------------------------------------------------------------
package cpc_bus_pkg;

  typedef enum logic [2:0] {
    MODE_NORMAL = 3'd0,  // no expansion mapping
    MODE_C1     = 3'd1,  // page 3 -> block 3
    MODE_C2     = 3'd2,  // all four pages -> blocks 0..3
    MODE_C3     = 3'd3,  // page 3 -> block 3, page 1 stays internal
    MODE_P1_B0  = 3'd4,  // page 1 -> block 0
    MODE_P1_B1  = 3'd5,  // page 1 -> block 1
    MODE_P1_B2  = 3'd6,  // page 1 -> block 2
    MODE_P1_B3  = 3'd7   // page 1 -> block 3
  } mode_e;

  localparam logic [1:0] GA_RAM_SEL = 2'b11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ARMED        = 2'd1,
    WAIT_RELEASE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/cpc_ram_map.sv
// -----------------------------------------------------------------------------
// cpc_ram_map
// Purely combinational memory-cycle decoder. Maps the 16KB page addressed by
// {a15,a14} onto an expansion block according to the active configuration and
// generates the internal-RAM disable and external SRAM strobes.
// Ports:
//   cfg                     in  {bank, mode} configuration register
//   a15, a14                in  Z80 page select
//   mreq_b, rd_b, wr_b      in  Z80 memory strobes (active-low)
//   rfsh_b                  in  Z80 refresh (active-low)
//   romen_b                 in  Gate Array ROM enable (active-low)
//   ramdis                  out internal RAM disabled this cycle
//   xa                      out external SRAM address bits 14 and above
//   xram_ce_b/oe_b/we_b     out external SRAM strobes (active-low)
// -----------------------------------------------------------------------------
module cpc_ram_map
  import cpc_bus_pkg::*;
#(
  parameter int NBANK_BITS = 3
) (
  input  logic [NBANK_BITS+2:0] cfg,
  input  logic                  a15,
  input  logic                  a14,
  input  logic                  mreq_b,
  input  logic                  rd_b,
  input  logic                  wr_b,
  input  logic                  rfsh_b,
  input  logic                  romen_b,
  output logic                  ramdis,
  output logic [NBANK_BITS+1:0] xa,
  output logic                  xram_ce_b,
  output logic                  xram_oe_b,
  output logic                  xram_we_b
);

  logic [NBANK_BITS-1:0] bank;
  logic [1:0]            page;
  logic                  hit;
  logic [1:0]            blk;
  logic                  sel;

  assign bank = cfg[NBANK_BITS+2:3];
  assign page = {a15, a14};

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    hit = 1'b0;
    blk = 2'd0;
    case (mode_e'(cfg[2:0]))
      MODE_NORMAL: ;
      MODE_C1, MODE_C3: begin
        if (page == 2'd3) begin
          hit = 1'b1;
          blk = 2'd3;
        end
      end
      MODE_C2: begin
        hit = 1'b1;
        blk = page;
      end
      default: begin
        // Modes 4..7: page 1 only, block number is mode-4 (the low two bits).
        if (page == 2'd1) begin
          hit = 1'b1;
          blk = cfg[1:0];
        end
      end
    endcase
  end

  // Refresh cycles carry a row address, not a real access: never select.
  assign sel       = hit & ~mreq_b & rfsh_b;
  assign ramdis    = sel;
  assign xa        = hit ? {bank, blk} : '0;
  assign xram_ce_b = ~sel;
  // An enabled ROM owns reads; writes still fall through to RAM.
  assign xram_oe_b = ~(sel & ~rd_b & romen_b);
  assign xram_we_b = ~(sel & ~wr_b);

endmodule

// File: rtl/cpc_ram_expander_ctrl.sv
// -----------------------------------------------------------------------------
// cpc_ram_expander_ctrl
// Expansion-bus responder for a CPC RAM expansion card. Snoops OUTs to the
// Gate Array RAM-configuration port, holds {bank, mode} in CFG and decodes
// each memory cycle through cpc_ram_map.
// Ports:
//   CLK, RESET_B                     bus clock, async active-low reset
//   A15, A14, D                      Z80 address page bits and data bus
//   IOREQ_B, MREQ_B, RD_B, WR_B,
//   M1_B, RFSH_B                     Z80 strobes (active-low)
//   ROMEN_B                          Gate Array ROM enable (active-low)
//   RAMDIS                           high = internal RAM disabled
//   XA                               external SRAM address bits 14 and up
//   XRAM_CE_B, XRAM_OE_B, XRAM_WE_B  external SRAM strobes
//   CFG                              current {bank, mode}
// -----------------------------------------------------------------------------
module cpc_ram_expander_ctrl
  import cpc_bus_pkg::*;
#(
  parameter int NBANK_BITS = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_B,
  input  logic                  A15,
  input  logic                  A14,
  input  logic [7:0]            D,
  input  logic                  IOREQ_B,
  input  logic                  MREQ_B,
  input  logic                  RD_B,
  input  logic                  WR_B,
  input  logic                  M1_B,
  input  logic                  RFSH_B,
  input  logic                  ROMEN_B,
  output logic                  RAMDIS,
  output logic [NBANK_BITS+1:0] XA,
  output logic                  XRAM_CE_B,
  output logic                  XRAM_OE_B,
  output logic                  XRAM_WE_B,
  output logic [NBANK_BITS+2:0] CFG
);

  cap_state_e state;
  logic       q;

  // Qualifying write to the RAM-config port. M1_B=1 excludes interrupt
  // acknowledge, which also asserts IOREQ_B.
  assign q = ~IOREQ_B & ~WR_B & M1_B & ~A15 & (D[7:6] == GA_RAM_SEL);

  // A CPC OUT spans two rising edges (TW and T3); requiring both filters
  // glitches, and WAIT_RELEASE stops a long write from reloading.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state <= IDLE;
      CFG   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q) state <= ARMED;
        end
        ARMED: begin
          if (q) begin
            CFG   <= {D[3 +: NBANK_BITS], D[2:0]};
            state <= WAIT_RELEASE;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (IOREQ_B || WR_B) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cpc_ram_map #(
    .NBANK_BITS(NBANK_BITS)
  ) u_map (
    .cfg      (CFG),
    .a15      (A15),
    .a14      (A14),
    .mreq_b   (MREQ_B),
    .rd_b     (RD_B),
    .wr_b     (WR_B),
    .rfsh_b   (RFSH_B),
    .romen_b  (ROMEN_B),
    .ramdis   (RAMDIS),
    .xa       (XA),
    .xram_ce_b(XRAM_CE_B),
    .xram_oe_b(XRAM_OE_B),
    .xram_we_b(XRAM_WE_B)
  );

endmodule

// File: tb/tb_cpc_ram_expander_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpc_ram_expander_ctrl
// Directed bench for cpc_ram_expander_ctrl with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_cpc_ram_expander_ctrl;
  import cpc_bus_pkg::*;

  localparam int NB = 3;

  logic          CLK = 1'b0;
  logic          RESET_B;
  logic          A15, A14;
  logic [7:0]    D;
  logic          IOREQ_B, MREQ_B, RD_B, WR_B, M1_B, RFSH_B, ROMEN_B;
  logic          RAMDIS;
  logic [NB+1:0] XA;
  logic          XRAM_CE_B, XRAM_OE_B, XRAM_WE_B;
  logic [NB+2:0] CFG;

  int n_checks = 0;
  int n_pass   = 0;

  cpc_ram_expander_ctrl #(.NBANK_BITS(NB)) dut (
    .CLK      (CLK),
    .RESET_B  (RESET_B),
    .A15      (A15),
    .A14      (A14),
    .D        (D),
    .IOREQ_B  (IOREQ_B),
    .MREQ_B   (MREQ_B),
    .RD_B     (RD_B),
    .WR_B     (WR_B),
    .M1_B     (M1_B),
    .RFSH_B   (RFSH_B),
    .ROMEN_B  (ROMEN_B),
    .RAMDIS   (RAMDIS),
    .XA       (XA),
    .XRAM_CE_B(XRAM_CE_B),
    .XRAM_OE_B(XRAM_OE_B),
    .XRAM_WE_B(XRAM_WE_B),
    .CFG      (CFG)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_idle();
    A15 = 1'b0; A14 = 1'b0; D = 8'h00;
    IOREQ_B = 1'b1; MREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1;
    M1_B = 1'b1; RFSH_B = 1'b1; ROMEN_B = 1'b1;
  endtask

  // Drive an I/O write to &7Fxx with data d (caller holds it across edges).
  task automatic drive_out(input logic [7:0] d);
    A15 = 1'b0; A14 = 1'b1; D = d;
    IOREQ_B = 1'b0; WR_B = 1'b0; M1_B = 1'b1; MREQ_B = 1'b1; RD_B = 1'b1;
  endtask

  // Complete OUT: two qualifying edges, then one released edge back to IDLE.
  task automatic out_cfg(input logic [7:0] d);
    @(negedge CLK); drive_out(d);
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); bus_idle();
    @(posedge CLK);
  endtask

  // Memory cycle at page {a15,a14}; outputs settle combinationally.
  task automatic mem_cycle(input logic a15, input logic a14, input logic rd,
                           input logic wr, input logic rfsh, input logic romen);
    @(negedge CLK);
    bus_idle();
    A15 = a15; A14 = a14; MREQ_B = 1'b0;
    RD_B = ~rd; WR_B = ~wr; RFSH_B = ~rfsh; ROMEN_B = ~romen;
    #1;
  endtask

  initial begin
    bus_idle();
    RESET_B = 1'b0;

    // Reset held: outputs forced quiet even with a page-3 read in flight.
    mem_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); @(negedge CLK); #1;
    check("rst_cfg",    32'(CFG),       32'h00);
    check("rst_ramdis", 32'(RAMDIS),    32'h0);
    check("rst_xa",     32'(XA),        32'h0);
    check("rst_strobes", 32'({XRAM_CE_B, XRAM_OE_B, XRAM_WE_B}), 32'h7);

    @(negedge CLK); RESET_B = 1'b1;

    // Mode 0 after reset: page-3 read stays internal.
    mem_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("m0_ramdis", 32'(RAMDIS),    32'h0);
    check("m0_ce",     32'(XRAM_CE_B), 32'h1);
    check("m0_cfg",    32'(CFG),       32'h00);

    // OUT &7F00,&C2 -> mode 2, bank 0.
    out_cfg(8'hC2);
    check("c2_cfg", 32'(CFG), 32'h02);
    mem_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // read 0x4000
    check("c2_p1_ramdis", 32'(RAMDIS),    32'h1);
    check("c2_p1_xa",     32'(XA),        32'h01);
    check("c2_p1_oe",     32'(XRAM_OE_B), 32'h0);
    check("c2_p1_we",     32'(XRAM_WE_B), 32'h1);
    mem_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // read 0xC000
    check("c2_p3_xa", 32'(XA), 32'h03);

    // OUT &7F00,&CD -> bank 1, mode 5 (page 1 -> block 1).
    out_cfg(8'hCD);
    check("cd_cfg", 32'(CFG), 32'h0D);
    mem_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // write 0x4123
    check("cd_wr_ramdis", 32'(RAMDIS),    32'h1);
    check("cd_wr_xa",     32'(XA),        32'h05);
    check("cd_wr_we",     32'(XRAM_WE_B), 32'h0);
    check("cd_wr_oe",     32'(XRAM_OE_B), 32'h1);
    mem_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // read 0xC000
    check("cd_p3_ramdis", 32'(RAMDIS), 32'h0);
    check("cd_p3_xa",     32'(XA),     32'h0);

    // Single qualifying edge: ARMED then back to IDLE without loading.
    @(negedge CLK); drive_out(8'hC2);
    @(posedge CLK);
    @(negedge CLK); bus_idle();
    @(posedge CLK); @(negedge CLK); #1;
    check("single_edge_cfg", 32'(CFG), 32'h0D);

    // Interrupt acknowledge (M1_B=0 with IOREQ_B=0) held three edges.
    @(negedge CLK); drive_out(8'hC7); M1_B = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); bus_idle(); #1;
    check("inta_cfg", 32'(CFG), 32'h0D);

    // A long write loads once; changed data while still held is ignored.
    @(negedge CLK); drive_out(8'hC1);
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); #1;
    check("long_first_load", 32'(CFG), 32'h01);
    D = 8'hC6;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); #1;
    check("long_no_reload", 32'(CFG), 32'h01);
    bus_idle();
    @(posedge CLK);

    // Mode 1 with ROM enabled at page 3.
    mem_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("m1_rom_ramdis", 32'(RAMDIS),    32'h1);
    check("m1_rom_oe",     32'(XRAM_OE_B), 32'h1);
    check("m1_rom_ce",     32'(XRAM_CE_B), 32'h0);
    mem_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("m1_rom_we", 32'(XRAM_WE_B), 32'h0);
    mem_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("m1_rfsh_ramdis", 32'(RAMDIS),    32'h0);
    check("m1_rfsh_ce",     32'(XRAM_CE_B), 32'h1);
    mem_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // page 1 not mapped in mode 1
    check("m1_p1_ramdis", 32'(RAMDIS), 32'h0);

    // Reset between the two edges of OUT &C4; bus keeps driving q throughout.
    @(negedge CLK); drive_out(8'hC4);
    @(posedge CLK);
    #2 RESET_B = 1'b0;
    #1;
    check("midrst_cfg",   32'(CFG),       32'h00);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    @(posedge CLK);
    @(negedge CLK); RESET_B = 1'b1; #1;
    check("post_rst_cfg",   32'(CFG),       32'h00);
    check("post_rst_state", 32'(dut.state), 32'(IDLE));
    @(posedge CLK); @(negedge CLK); #1;
    check("post_rst_one_edge", 32'(CFG), 32'h00);
    @(posedge CLK); @(negedge CLK); #1;
    check("post_rst_two_edges", 32'(CFG), 32'h04);
    bus_idle();
    @(posedge CLK);

    // Follow-up complete OUT &C4 and mode-4 decode (page 1 -> block 0).
    out_cfg(8'hC4);
    check("c4_cfg", 32'(CFG), 32'h04);
    mem_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("c4_p1_ramdis", 32'(RAMDIS), 32'h1);
    check("c4_p1_xa",     32'(XA),     32'h00);
    mem_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("c4_p2_ramdis", 32'(RAMDIS), 32'h0);

    // Top data bits above the bank field are ignored: &FD -> bank 7, mode 5.
    out_cfg(8'hFD);
    check("fd_cfg", 32'(CFG), 32'h3D);
    mem_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fd_xa", 32'(XA), 32'h1D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpc_ram_expander_ctrl.md
# cpc_ram_expander_ctrl

Bus-responder controller for a CPC RAM expansion card plugged into the 50-way expansion bus. It snoops Z80 I/O writes to the Gate Array RAM-configuration port, holds the active bank/mode in a register, and decodes each memory cycle. For accesses that belong to the expansion it asserts RAMDIS to disable internal RAM and drives the external SRAM's upper address and strobes. It is the peripheral end of the bus that the backplane distributes.

## Interface
Parameters:
- NBANK_BITS, 3, number of 64KB expansion bank select bits (3 gives 512KB); XA width = NBANK_BITS+2

Ports:
- CLK  in  1  CPC bus clock (4MHz), sole clock; all state changes on rising edge
- RESET_B  in  1  asynchronous, active-low reset, from bus RESET_B
- A15, A14  in  1 each  Z80 address bits
- D  in  8  Z80 data bus D7..D0
- IOREQ_B, MREQ_B, RD_B, WR_B, M1_B, RFSH_B  in  1 each  Z80 strobes, active-low
- ROMEN_B  in  1  Gate Array ROM enable, active-low
- RAMDIS  out  1  high = internal RAM disabled for this cycle
- XA  out  NBANK_BITS+2  external SRAM address bits 14 and above
- XRAM_CE_B, XRAM_OE_B, XRAM_WE_B  out  1 each  external SRAM strobes
- CFG  out  NBANK_BITS+3  current configuration register {bank, mode}

## Operation
- Qualifying I/O write (q): IOREQ_B=0, WR_B=0, M1_B=1, A15=0, D[7:6]=2'b11.
- Capture FSM, states IDLE, ARMED, WAIT_RELEASE:
  - IDLE: q -> ARMED; else stay.
  - ARMED: q -> load CFG <= {D[3+NBANK_BITS-1:3], D[2:0]}, go to WAIT_RELEASE; not q -> IDLE, no load.
  - WAIT_RELEASE: IOREQ_B=1 or WR_B=1 -> IDLE; else stay. No further loads until then.
- D bits above the bank field are ignored.
- Mode decode (m = CFG[2:0], b = bank, page p = {A15,A14}); hit and block k:
  - m=0: no hit.
  - m=1: p=3 -> k=3.
  - m=2: all p -> k=p.
  - m=3: p=3 -> k=3. Page 1 is left to the internal RAM.
  - m=4..7: p=1 -> k=m-4.
- sel = hit & ~MREQ_B & RFSH_B.
- RAMDIS = sel. XA = {b, k[1:0]}; XA = 0 when not hit.
- XRAM_CE_B = ~sel.
- XRAM_OE_B = ~(sel & ~RD_B & ROMEN_B). ROM reads win.
- XRAM_WE_B = ~(sel & ~WR_B). Writes under an enabled ROM still land in RAM.
- Refresh cycles (RFSH_B=0) and interrupt acknowledge (M1_B=0 with IOREQ_B=0) never load CFG and never select.

## Timing
- Reset (async, RESET_B=0): FSM=IDLE, CFG=0. As a result RAMDIS=0, XA=0, and all XRAM strobes=1. These values hold as long as RESET_B stays low.
- Reset asserted mid-write clears everything immediately. After release, the interrupted write needs two fresh qualifying samples before it loads.
- CFG loads on the second consecutive qualifying rising edge (CPC I/O write spans the TW and T3 edges). The new mapping is visible on the cycle after that edge.
- A single isolated qualifying sample never loads CFG.
- Memory decode is combinational from registered CFG and the live bus, with zero clock latency. There is no combinational path from D to any output.
- Back-to-back OUTs: the second load requires one sample in IDLE with IOREQ_B or WR_B high in between.

## Structure
- Shared package cpc_bus_pkg:
  - mode encodings MODE_NORMAL=0 … MODE_P1_B3=7
  - GA_RAM_SEL=2'b11
  - FSM state enum
- One sub-module, cpc_ram_map: a purely combinational decoder taking CFG, A15:A14, strobes and ROMEN_B, producing RAMDIS, XA and the strobes.
- The top level holds the FSM and the CFG register.

## Test plan
- Reset, then a memory read at page 3: RAMDIS=0, XRAM_CE_B=1, CFG=0.
- OUT &7F00,&C2 (two qualifying edges), then MREQ read at 0x4000: CFG=0x02, RAMDIS=1, XA=5'b00001, XRAM_OE_B=0.
- OUT &7F00,&CD (bank 1, mode 5), then write at 0x4123: RAMDIS=1, XA=5'b00101, XRAM_WE_B=0. A read at 0xC000 gives RAMDIS=0.
- Qualifying pattern for a single edge only, and an interrupt-acknowledge cycle with D=&C7: CFG unchanged.
- Mode 1 active with ROMEN_B=0, read at 0xC000: RAMDIS=1, XRAM_OE_B=1. The same address with WR_B=0 gives XRAM_WE_B=0. A refresh cycle at 0xC000 gives RAMDIS=0.
- RESET_B pulsed low between the two edges of an OUT &7F00,&C4: CFG=0 and FSM=IDLE after release. A following complete OUT loads 0x04.
